// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared constants and FSM states for the histogram observation generator
package hist_pkg;
  localparam int NOBS = 4;
  localparam int DW   = 8;
  localparam int CW   = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_REJ  = 2'd2
  } state_t;
endpackage

// File: rtl/hist_obs_gen_if.sv
// rtl/hist_obs_gen_if.sv - descriptor input and observation output handshakes
interface hist_obs_gen_if #(parameter int DW = hist_pkg::DW);
  import hist_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] b1;
  logic [DW-1:0] b2;
  logic [CW-1:0] n;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] obs;
  logic [1:0]    obs_idx;
  logic          obs_last;
  logic          err;

  modport master (
    output in_valid, b1, b2, n, out_ready,
    input  in_ready, out_valid, obs, obs_idx, obs_last, err
  );

  modport slave (
    input  in_valid, b1, b2, n, out_ready,
    output in_ready, out_valid, obs, obs_idx, obs_last, err
  );
endinterface

// File: rtl/hist_wrap_ctr.sv
// rtl/hist_wrap_ctr.sv - in-bin value counter: load, increment, wrap from hi back to lo
module hist_wrap_ctr #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          inc,
  input  logic [DW-1:0] lo,
  input  logic [DW-1:0] hi,
  output logic [DW-1:0] value
);
  // Equality test against hi keeps the increment from ever reaching past the bin top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= (value == hi) ? lo : value + DW'(1);
    end
  end
endmodule

// File: rtl/hist_obs_gen.sv
// rtl/hist_obs_gen.sv - emits NOBS observations whose inclusive [b1,b2] bin count equals n
module hist_obs_gen
  import hist_pkg::*;
#(
  parameter int NOBS = hist_pkg::NOBS,
  parameter int DW   = hist_pkg::DW
) (
  input  logic           clk,
  input  logic           rst_n,
  hist_obs_gen_if.slave  bus
);
  localparam logic [DW-1:0] MAXV     = '1;
  localparam logic [1:0]    LAST_IDX = 2'(NOBS - 1);
  localparam logic [CW-1:0] NOBS_C   = CW'(NOBS);

  state_t        state_q, state_nxt;
  logic [DW-1:0] b1_q, b2_q, ctr_val, fill;
  logic [CW-1:0] n_q;
  logic [1:0]    idx_q;
  logic          accept, beat, bad, in_bin;

  assign accept = (state_q == S_IDLE) && bus.in_valid;
  assign beat   = (state_q == S_EMIT) && bus.out_ready;

  // A full-range bin leaves no out-of-bin value, so only n==NOBS is satisfiable there.
  assign bad = (bus.n > NOBS_C) || (bus.b1 > bus.b2) ||
               ((bus.b1 == '0) && (bus.b2 == MAXV) && (bus.n < NOBS_C));

  assign in_bin = {1'b0, idx_q} < n_q;
  assign fill   = (b2_q != MAXV) ? b2_q + DW'(1) : b1_q - DW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (accept) state_nxt = bad ? S_REJ : S_EMIT;
      S_EMIT: if (beat && (idx_q == LAST_IDX)) state_nxt = S_IDLE;
      S_REJ:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1_q  <= '0;
      b2_q  <= '0;
      n_q   <= '0;
      idx_q <= '0;
    end else begin
      if (accept) begin
        b1_q  <= bus.b1;
        b2_q  <= bus.b2;
        n_q   <= bus.n;
        idx_q <= '0;
      end else if (beat) begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  hist_wrap_ctr #(.DW(DW)) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (bus.b1),
    .inc      (beat && in_bin),
    .lo       (b1_q),
    .hi       (b2_q),
    .value    (ctr_val)
  );

  // Outputs decode from registered state only, so they hold steady across stalls.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.obs       = (state_q == S_EMIT) ? (in_bin ? ctr_val : fill) : '0;
  assign bus.obs_idx   = idx_q;
  assign bus.obs_last  = (state_q == S_EMIT) && (idx_q == LAST_IDX);
  assign bus.err       = (state_q == S_REJ);
endmodule

// File: tb/tb_hist_obs_gen.sv
// tb/tb_hist_obs_gen.sv - self-checking bench for hist_obs_gen
module tb_hist_obs_gen;
  typedef struct {
    int obs;
    int idx;
    bit last;
    int b1;
    int b2;
    int n;
  } beat_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   chk_en;
  bit   err_exp;
  bit   stall;
  int   bin_cnt;
  beat_t exp_q[$];
  int    log_q[$];
  bit    prev_stall;
  int    prev_obs;

  hist_obs_gen_if bus ();

  hist_obs_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-bin values cycle through the bin span; fill lies just outside the bin.
  function automatic bit desc_valid(input int b1v, input int b2v, input int nv);
    int span;
    span = b2v - b1v + 1;
    return (nv <= 4) && (b1v <= b2v) && ((nv == 4) || (span < 256));
  endfunction

  function automatic int model_obs(input int b1v, input int b2v, input int nv, input int i);
    if (i < nv) return b1v + (i % (b2v - b1v + 1));
    return (b2v < 255) ? b2v + 1 : b1v - 1;
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      int pi;
      bit pat[4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      @(posedge clk);
      #1;
      if (stall) begin
        bus.out_ready = pat[pi];
        pi = (pi + 1) % 4;
      end else begin
        bus.out_ready = 1'b1;
        pi = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      check("in_ready", bus.in_ready, (exp_q.size() == 0) && !err_exp);
      check("err", bus.err, err_exp);
      if (prev_stall && bus.out_valid) check("obs_hold", bus.obs, prev_obs);
      if (bus.out_valid && exp_q.size() != 0) begin
        check("obs", bus.obs, exp_q[0].obs);
        check("obs_idx", bus.obs_idx, exp_q[0].idx);
        check("obs_last", bus.obs_last, exp_q[0].last);
        if (bus.out_ready) begin
          log_q.push_back(int'(bus.obs));
          if (int'(bus.obs) >= exp_q[0].b1 && int'(bus.obs) <= exp_q[0].b2) bin_cnt++;
          if (exp_q[0].last) begin
            check("bin_count", bin_cnt, exp_q[0].n);
            bin_cnt = 0;
          end
          void'(exp_q.pop_front());
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_obs   = int'(bus.obs);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input int b1v, input int b2v, input int nv);
    int cnt;
    bus.b1 = b1v[7:0];
    bus.b2 = b2v[7:0];
    bus.n  = nv[2:0];
    bus.in_valid = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!bus.in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("accept_wait", cnt < 100, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.b1 = 8'($urandom);
    bus.b2 = 8'($urandom);
    bus.n  = 3'($urandom);
    if (!desc_valid(b1v, b2v, nv)) begin
      err_exp = 1'b1;
      @(posedge clk);
      #1;
      err_exp = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        beat_t bt;
        bt.obs = model_obs(b1v, b2v, nv, i);
        bt.idx = i;
        bt.last = (i == 3);
        bt.b1 = b1v;
        bt.b2 = b2v;
        bt.n = nv;
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || err_exp) && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain_wait", cnt < 200, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_log(input int a, input int b, input int c, input int d);
    check("log_len", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("grp_obs0", log_q[0], a);
      check("grp_obs1", log_q[1], b);
      check("grp_obs2", log_q[2], c);
      check("grp_obs3", log_q[3], d);
    end
    log_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_obs", bus.obs, 0);
    check("rst_obs_idx", bus.obs_idx, 0);
    check("rst_obs_last", bus.obs_last, 0);
    check("rst_err", bus.err, 0);
    check("rst_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_rejected(input int b1v, input int b2v, input int nv);
    send(b1v, b2v, nv);
    wait_idle();
    check("rej_no_beats", log_q.size(), 0);
    log_q.delete();
  endtask

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    err_exp = 1'b0;
    stall = 1'b0;
    bin_cnt = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.b1 = '0;
    bus.b2 = '0;
    bus.n = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    send(0, 3, 3);    wait_idle(); expect_log(0, 1, 2, 4);
    send(0, 9, 2);    wait_idle(); expect_log(0, 1, 10, 10);
    send(5, 5, 4);    wait_idle(); expect_log(5, 5, 5, 5);
    send(10, 255, 1); wait_idle(); expect_log(10, 9, 9, 9);
    send(0, 255, 4);  wait_idle(); expect_log(0, 1, 2, 3);
    send(250, 255, 0); wait_idle(); expect_log(249, 249, 249, 249);
    send(3, 4, 4);    wait_idle(); expect_log(3, 4, 3, 4);

    run_rejected(0, 255, 2);
    run_rejected(7, 3, 1);
    run_rejected(1, 2, 5);

    stall = 1'b1;
    send(0, 3, 3);    wait_idle(); expect_log(0, 1, 2, 4);
    stall = 1'b0;
    @(posedge clk);
    #1;

    send(0, 9, 2);
    cnt = 0;
    while (log_q.size() < 2 && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("second_beat_wait", cnt < 50, 1);
    rst_n = 1'b0;
    chk_en = 1'b0;
    exp_q.delete();
    bin_cnt = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_beats", log_q.size(), 2);
    log_q.delete();
    send(5, 5, 4);    wait_idle(); expect_log(5, 5, 5, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
